// File: rtl/line_buffer_column.sv
// Turns the raster pixel stream into an M_DEPTH-tall column: the current pixel plus the pixels at the
// same x on the previous M_DEPTH-1 lines, with timing signals delayed by the same single cycle.
module line_buffer_column #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600,
    parameter int LINE_END    = 2048,
    parameter int M_DEPTH     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COLORDEPTH-1:0]         px_i,
    input  logic                          dv_i,
    input  logic                          hs_i,
    input  logic                          vs_i,
    output logic [COLORDEPTH*M_DEPTH-1:0] vect_o,
    output logic                          dv_o,
    output logic                          hs_o,
    output logic                          vs_o,
    output logic                          line_end_o,
    output logic                          ovf_o
);
    localparam int NR = M_DEPTH - 1;
    localparam int XW = (LINE_END > 1) ? $clog2(LINE_END) : 1;
    localparam int SW = (NR > 1) ? $clog2(NR) : 1;
    localparam int RW = $clog2(M_DEPTH);

    logic [XW-1:0]            r_x_cnt;
    logic                     r_full;
    logic [SW-1:0]            r_wr_sel;
    logic [RW-1:0]            r_row_cnt;
    logic [COLORDEPTH-1:0]    r_px;
    logic                     r_dv;
    logic                     r_hs;
    logic                     r_vs;
    logic                     r_line_end;
    logic                     r_ovf;
    logic [NR*COLORDEPTH-1:0] w_rd_bus;
    logic                     w_line_end;
    logic                     w_frame_start;
    logic                     w_wr;
    logic [SW-1:0]            w_wr_sel_next;

    // Lines wider than the RAM are legal input; they simply raise ovf_o.
    if (SCREENWIDTH > LINE_END) begin : g_lines_exceed_ram
    end

    assign w_line_end    = r_dv & ~dv_i;
    assign w_frame_start = vs_i & ~r_vs;
    assign w_wr          = dv_i & ~r_full & ~rst;
    assign w_wr_sel_next = (r_wr_sel == SW'(NR - 1)) ? '0 : r_wr_sel + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt    <= '0;
            r_full     <= 1'b0;
            r_wr_sel   <= '0;
            r_row_cnt  <= '0;
            r_px       <= '0;
            r_dv       <= 1'b0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
            r_line_end <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_dv       <= dv_i;
            r_hs       <= hs_i;
            r_vs       <= vs_i;
            r_line_end <= w_line_end;
            if (dv_i) begin
                r_px <= px_i;
            end
            // Frame start outranks a coincident line end.
            if (w_frame_start) begin
                r_x_cnt   <= '0;
                r_full    <= 1'b0;
                r_wr_sel  <= '0;
                r_row_cnt <= '0;
                r_ovf     <= 1'b0;
            end else if (w_line_end) begin
                r_x_cnt  <= '0;
                r_full   <= 1'b0;
                r_wr_sel <= w_wr_sel_next;
                if (r_row_cnt != RW'(NR)) begin
                    r_row_cnt <= r_row_cnt + RW'(1);
                end
            end else if (dv_i) begin
                // r_full marks that the last RAM slot has been written; later pixels are dropped.
                if (r_full) begin
                    r_ovf <= 1'b1;
                end else if (r_x_cnt == XW'(LINE_END - 1)) begin
                    r_full <= 1'b1;
                end else begin
                    r_x_cnt <= r_x_cnt + XW'(1);
                end
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NR; gi++) begin : g_ram
        logic [COLORDEPTH-1:0] mem [0:LINE_END-1];
        logic [COLORDEPTH-1:0] r_rd;

        // Read-before-write: the slot being overwritten returns the line written NR lines ago.
        always_ff @(posedge clk) begin
            if (w_wr && (r_wr_sel == SW'(gi))) begin
                mem[r_x_cnt] <= px_i;
            end
            r_rd <= mem[r_x_cnt];
        end

        assign w_rd_bus[gi*COLORDEPTH +: COLORDEPTH] = r_rd;
    end

    for (gi = 1; gi < M_DEPTH; gi++) begin : g_tap
        int            w_diff;
        logic [SW-1:0] w_sel;
        logic [SW-1:0] r_sel;
        logic          r_mask;

        always_comb begin
            w_diff = int'(r_wr_sel) - gi;
            if (w_diff < 0) begin
                w_diff = w_diff + NR;
            end
        end
        assign w_sel = SW'(w_diff);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_mask <= 1'b0;
            end else begin
                r_mask <= (int'(r_row_cnt) >= gi) && !r_full;
            end
            r_sel <= w_sel;
        end

        assign vect_o[gi*COLORDEPTH +: COLORDEPTH] =
            r_mask ? w_rd_bus[int'(r_sel)*COLORDEPTH +: COLORDEPTH] : '0;
    end

    assign vect_o[COLORDEPTH-1:0] = r_px;
    assign dv_o       = r_dv;
    assign hs_o       = r_hs;
    assign vs_o       = r_vs;
    assign line_end_o = r_line_end;
    assign ovf_o      = r_ovf;
endmodule

// File: tb/tb_line_buffer_column.sv
// Bench for line_buffer_column: a short-RAM instance for fill/overflow/reset cases and a full-size
// instance for back-to-back 1600-pixel lines, both checked against a scoreboard of expected columns.
module tb_line_buffer_column;
    localparam int CD   = 8;
    localparam int MD   = 3;
    localparam int LE_A = 16;
    localparam int LE_B = 2048;
    localparam int SW_B = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  px_a, px_b;
    logic        dv_a, hs_a, vs_a, dv_b, hs_b, vs_b;
    logic [23:0] vect_a, vect_b;
    logic        dvo_a, hso_a, vso_a, leo_a, ovf_a;
    logic        dvo_b, hso_b, vso_b, leo_b, ovf_b;

    line_buffer_column #(.COLORDEPTH(CD), .SCREENWIDTH(LE_A), .LINE_END(LE_A), .M_DEPTH(MD)) dut_a (
        .clk(clk), .rst(rst), .px_i(px_a), .dv_i(dv_a), .hs_i(hs_a), .vs_i(vs_a),
        .vect_o(vect_a), .dv_o(dvo_a), .hs_o(hso_a), .vs_o(vso_a), .line_end_o(leo_a), .ovf_o(ovf_a)
    );

    line_buffer_column #(.COLORDEPTH(CD), .SCREENWIDTH(SW_B), .LINE_END(LE_B), .M_DEPTH(MD)) dut_b (
        .clk(clk), .rst(rst), .px_i(px_b), .dv_i(dv_b), .hs_i(hs_b), .vs_i(vs_b),
        .vect_o(vect_b), .dv_o(dvo_b), .hs_o(hso_b), .vs_o(vso_b), .line_end_o(leo_b), .ovf_o(ovf_b)
    );

    typedef struct packed {
        logic [23:0] vect;
        logic        ovf;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] hist [0:1][0:7][0:2047];
    int         row_m[2];
    int         xm[2];
    int         lines_m[2];
    logic       ovf_m[2];
    int         le_cnt[2];
    logic       le_prev[2];
    int         le_dbl;
    int         n_cmp;
    int         n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic dv, input logic [7:0] p);
        if (d == 0) begin
            dv_a = dv;
            px_a = p;
        end else begin
            dv_b = dv;
            px_b = p;
        end
    endtask

    // Golden model: rows above the top of the frame and pixels past the RAM end read as 0.
    task automatic drive_px(input int d, input logic [7:0] p);
        exp_t       e;
        int         le;
        logic [7:0] v1, v2;
        le = (d == 0) ? LE_A : LE_B;
        v1 = (row_m[d] >= 1 && xm[d] < le) ? hist[d][(row_m[d] - 1) % 8][xm[d]] : 8'h00;
        v2 = (row_m[d] >= 2 && xm[d] < le) ? hist[d][(row_m[d] - 2) % 8][xm[d]] : 8'h00;
        if (xm[d] >= le) ovf_m[d] = 1'b1;
        else hist[d][row_m[d] % 8][xm[d]] = p;
        e.vect = {v2, v1, p};
        e.ovf  = ovf_m[d];
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
        xm[d]++;
        set_in(d, 1'b1, p);
        step();
    endtask

    task automatic end_line(input int d, input int idle);
        set_in(d, 1'b0, 8'h00);
        row_m[d]++;
        xm[d] = 0;
        lines_m[d]++;
        step();
        if (d == 0) begin
            check("line_end_pulse", 32'({dvo_a, leo_a}), 32'h1);
        end
        for (int i = 1; i < idle; i++) begin
            step();
            if (d == 0 && i == 1) check("line_end_width", 32'(leo_a), 32'h0);
        end
    endtask

    task automatic frame_start(input int d);
        if (d == 0) vs_a = 1'b1;
        else vs_b = 1'b1;
        step();
        if (d == 0) vs_a = 1'b0;
        else vs_b = 1'b0;
        row_m[d] = 0;
        xm[d]    = 0;
        ovf_m[d] = 1'b0;
        step();
    endtask

    function automatic logic sync_out(input int sig);
        return (sig == 0) ? hso_a : vso_a;
    endfunction

    task automatic lat(input string tag, input int sig, input logic val);
        if (sig == 0) hs_a = val;
        else vs_a = val;
        check({tag, "_pre"}, 32'(sync_out(sig)), 32'(!val));
        step();
        check({tag, "_post"}, 32'(sync_out(sig)), 32'(val));
    endtask

    initial begin
        exp_t em;
        n_cmp = 0;
        n_bad = 0;
        le_dbl = 0;
        for (int d = 0; d < 2; d++) begin
            row_m[d] = 0; xm[d] = 0; lines_m[d] = 0; ovf_m[d] = 1'b0;
            le_cnt[d] = 0; le_prev[d] = 1'b0;
        end
        rst = 1'b1;
        px_a = 8'h5A; dv_a = 1'b1; hs_a = 1'b1; vs_a = 1'b1;
        px_b = 8'h00; dv_b = 1'b0; hs_b = 1'b0; vs_b = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (dvo_a) begin
                    if (q_a.size() == 0) check("a_spurious_dv", 32'(dvo_a), 32'h0);
                    else begin
                        em = q_a.pop_front();
                        check("a_vect", 32'(vect_a), 32'(em.vect));
                        check("a_ovf", 32'(ovf_a), 32'(em.ovf));
                    end
                end
                if (dvo_b) begin
                    if (q_b.size() == 0) check("b_spurious_dv", 32'(dvo_b), 32'h0);
                    else begin
                        em = q_b.pop_front();
                        check("b_vect", 32'(vect_b), 32'(em.vect));
                        check("b_ovf", 32'(ovf_b), 32'(em.ovf));
                    end
                end
                if (leo_a) begin
                    le_cnt[0]++;
                    if (le_prev[0]) le_dbl++;
                end
                if (leo_b) begin
                    le_cnt[1]++;
                    if (le_prev[1]) le_dbl++;
                end
                le_prev[0] = leo_a;
                le_prev[1] = leo_b;
            end
        join_none

        // Power-on reset with the inputs active.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_init_out", 32'({vect_a, dvo_a, hso_a, vso_a, leo_a, ovf_a}), 32'h0);
        end
        rst = 1'b0; dv_a = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
        step();

        // Sync pass-through latency; the vs rise also opens the ramp frame.
        lat("hs_rise", 0, 1'b1);
        lat("hs_fall", 0, 1'b0);
        lat("vs_rise", 1, 1'b1);
        lat("vs_fall", 1, 1'b0);

        // Ramp frame: px = 16*line + x.
        check("dv_rise_pre", 32'(dvo_a), 32'h0);
        for (int l = 0; l < 4; l++) begin
            for (int x = 0; x < 8; x++) begin
                drive_px(0, 8'(16 * l + x));
                if (l == 0 && x == 0) check("dv_rise_post", 32'(dvo_a), 32'h1);
            end
            end_line(0, 3);
        end

        // New frame must not see the previous frame's lines.
        frame_start(0);
        for (int x = 0; x < 8; x++) drive_px(0, 8'(8'hA0 + x));
        end_line(0, 3);
        for (int x = 0; x < 8; x++) drive_px(0, 8'(8'hB0 + x));
        end_line(0, 3);

        // Overflow: third line is 20 px into a 16-entry RAM.
        frame_start(0);
        for (int x = 0; x < 16; x++) drive_px(0, 8'(8'h40 + x));
        end_line(0, 3);
        for (int x = 0; x < 16; x++) drive_px(0, 8'(8'h50 + x));
        end_line(0, 3);
        for (int x = 0; x < 20; x++) drive_px(0, 8'(8'hC0 + x));
        end_line(0, 3);
        for (int x = 0; x < 16; x++) drive_px(0, 8'(8'h60 + x));
        end_line(0, 3);
        frame_start(0);
        check("ovf_clear_on_vs", 32'(ovf_a), 32'h0);

        // Reset in the middle of a line, then the next line is row 0 again.
        for (int x = 0; x < 5; x++) drive_px(0, 8'(8'h70 + x));
        rst = 1'b1;
        hs_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            px_a = 8'($urandom);
            step();
            check("rst_mid_out", 32'({vect_a, dvo_a, hso_a, vso_a, leo_a, ovf_a}), 32'h0);
        end
        rst = 1'b0; dv_a = 1'b0; hs_a = 1'b0;
        row_m[0] = 0; xm[0] = 0; ovf_m[0] = 1'b0;
        step();
        for (int x = 0; x < 8; x++) drive_px(0, 8'(8'h80 + x));
        end_line(0, 3);
        for (int x = 0; x < 8; x++) drive_px(0, 8'(8'h90 + x));
        end_line(0, 3);

        // Full-width lines with a single idle cycle between them.
        frame_start(1);
        for (int l = 0; l < 4; l++) begin
            for (int x = 0; x < SW_B; x++) drive_px(1, 8'($urandom));
            end_line(1, 1);
        end

        repeat (4) step();
        check("a_queue_drained", 32'(q_a.size()), 32'h0);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);
        check("a_line_end_count", 32'(le_cnt[0]), 32'(lines_m[0]));
        check("b_line_end_count", 32'(le_cnt[1]), 32'(lines_m[1]));
        check("line_end_single_cycle", 32'(le_dbl), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
